// File: rtl/toy_mem_arbiter.sv
// toy_mem_arbiter
//
// Shares one single-port synchronous SRAM between the instruction-fetch (I)
// requester and the load/store (D) requester. At most one access is granted
// per cycle. D has priority, but once I has been refused STARVE_MAX
// consecutive cycles it wins the next contended cycle. Read data comes back
// from the SRAM one cycle after the grant. Ownership is tracked so that only
// the side that issued the read sees an RVALID pulse.
//
// Parameters
//   AW         word-address width of both requesters and M_A
//   DW         data width
//   STARVE_MAX refusals of I_REQ tolerated before I wins (1..15)
//
// Ports
//   CLK, RSTN                  clock (rising edge), async active-low reset
//   I_REQ/I_ADDR               fetch request, held until I_GNT
//   I_GNT                      fetch accepted this cycle (combinational)
//   I_RVALID/I_RDATA           fetch data, one cycle after I_GNT
//   D_REQ/D_RW/D_ADDR/D_WDATA  data request (D_RW=1 write), held until D_GNT
//   D_GNT                      data access accepted this cycle (combinational)
//   D_RVALID/D_RDATA           load data, one cycle after a read D_GNT
//   M_CSN/M_WEN                SRAM chip select / write enable, active low
//   M_A/M_DI                   SRAM address / write data
//   M_DOUT                     SRAM read data, valid the cycle after access
//
// Optional build macro ARB_STATS_EN adds saturating 16-bit counters:
//   I_GNT_CNT   I grants
//   D_GNT_CNT   D grants
//   STARVE_HIT  cycles where I won only through the starvation override
// Arbitration is identical with or without the macro.

module toy_mem_arbiter #(
  parameter int unsigned AW         = 30,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_GNT,
  output logic          I_RVALID,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_GNT,
  output logic          D_RVALID,
  output logic [DW-1:0] D_RDATA,
  output logic          M_CSN,
  output logic          M_WEN,
  output logic [AW-1:0] M_A,
  output logic [DW-1:0] M_DI,
  input  logic [DW-1:0] M_DOUT
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   I_GNT_CNT,
  output logic [15:0]   D_GNT_CNT,
  output logic [15:0]   STARVE_HIT
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]    r_starve_cnt;
  logic          r_rvalid;
  logic          r_owner;      // 1 = D issued the pending read, 0 = I
  logic [AW-1:0] r_a_hold;
  logic [DW-1:0] r_di_hold;

  logic          w_starve_ovr;
  logic          w_i_gnt;
  logic          w_d_gnt;
  logic          w_gnt;
  logic [AW-1:0] w_m_a;
  logic [DW-1:0] w_m_di;

  // Grants are combinational so an idle port gives a zero-wait grant.
  // RSTN gates them so nothing reaches the SRAM while in reset.
  always_comb begin
    w_starve_ovr = I_REQ & D_REQ & (r_starve_cnt >= StarveMax);
    w_d_gnt      = RSTN & D_REQ & ~w_starve_ovr;
    w_i_gnt      = RSTN & I_REQ & ~w_d_gnt;
    w_gnt        = w_i_gnt | w_d_gnt;

    // Without a grant, address and write data hold their last driven value
    // so the SRAM pins do not toggle needlessly.
    w_m_a = r_a_hold;
    if (w_d_gnt) begin
      w_m_a = D_ADDR;
    end else if (w_i_gnt) begin
      w_m_a = I_ADDR;
    end
    w_m_di = w_d_gnt ? D_WDATA : r_di_hold;
  end

  assign I_GNT   = w_i_gnt;
  assign D_GNT   = w_d_gnt;
  assign M_CSN   = ~w_gnt;
  assign M_WEN   = ~(w_d_gnt & D_RW);
  assign M_A     = w_m_a;
  assign M_DI    = w_m_di;

  // Both sides see the SRAM output directly; RVALID alone says whose it is.
  assign I_RDATA  = M_DOUT;
  assign D_RDATA  = M_DOUT;
  assign I_RVALID = r_rvalid & ~r_owner;
  assign D_RVALID = r_rvalid &  r_owner;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_starve_cnt <= 4'd0;
      r_rvalid     <= 1'b0;
      r_owner      <= 1'b0;
      r_a_hold     <= '0;
      r_di_hold    <= '0;
    end else begin
      if (!I_REQ || w_i_gnt) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != 4'hF) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      // Writes never produce a response; a reset in between drops the
      // pending one because r_rvalid is cleared asynchronously.
      r_rvalid <= w_i_gnt | (w_d_gnt & ~D_RW);
      r_owner  <= w_d_gnt;

      if (w_gnt) begin
        r_a_hold <= w_m_a;
      end
      if (w_d_gnt) begin
        r_di_hold <= D_WDATA;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_i_gnt_cnt;
  logic [15:0] r_d_gnt_cnt;
  logic [15:0] r_starve_hit;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_i_gnt_cnt  <= 16'd0;
      r_d_gnt_cnt  <= 16'd0;
      r_starve_hit <= 16'd0;
    end else begin
      if (w_i_gnt && r_i_gnt_cnt != 16'hFFFF) begin
        r_i_gnt_cnt <= r_i_gnt_cnt + 16'd1;
      end
      if (w_d_gnt && r_d_gnt_cnt != 16'hFFFF) begin
        r_d_gnt_cnt <= r_d_gnt_cnt + 16'd1;
      end
      // w_starve_ovr already implies D was requesting, so this I grant
      // would have gone to D without the override.
      if (w_i_gnt && w_starve_ovr && r_starve_hit != 16'hFFFF) begin
        r_starve_hit <= r_starve_hit + 16'd1;
      end
    end
  end

  assign I_GNT_CNT  = r_i_gnt_cnt;
  assign D_GNT_CNT  = r_d_gnt_cnt;
  assign STARVE_HIT = r_starve_hit;
`endif

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Self-checking bench for toy_mem_arbiter: directed scenarios followed by
// random traffic, checked every cycle against a request-level model of the
// arbitration rules and a reference copy of memory contents.

module tb_toy_mem_arbiter;

  localparam int unsigned AW         = 30;
  localparam int unsigned DW         = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req, d_req, d_rw;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          m_csn, m_wen;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_di;
  logic [DW-1:0] m_dout;
`ifdef ARB_STATS_EN
  logic [15:0]   i_gnt_cnt, d_gnt_cnt, starve_hit;
`endif

  toy_mem_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK        (clk),
    .RSTN       (rstn),
    .I_REQ      (i_req),
    .I_ADDR     (i_addr),
    .I_GNT      (i_gnt),
    .I_RVALID   (i_rvalid),
    .I_RDATA    (i_rdata),
    .D_REQ      (d_req),
    .D_RW       (d_rw),
    .D_ADDR     (d_addr),
    .D_WDATA    (d_wdata),
    .D_GNT      (d_gnt),
    .D_RVALID   (d_rvalid),
    .D_RDATA    (d_rdata),
    .M_CSN      (m_csn),
    .M_WEN      (m_wen),
    .M_A        (m_a),
    .M_DI       (m_di),
    .M_DOUT     (m_dout)
`ifdef ARB_STATS_EN
    ,
    .I_GNT_CNT  (i_gnt_cnt),
    .D_GNT_CNT  (d_gnt_cnt),
    .STARVE_HIT (starve_hit)
`endif
  );

  always #5 clk = ~clk;

  // Environment: behavioural single-port synchronous SRAM (256 words used).
  logic [DW-1:0] sram [256];
  always @(posedge clk) begin
    if (!m_csn) begin
      if (!m_wen) sram[m_a[7:0]] <= m_di;
      else        m_dout <= sram[m_a[7:0]];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int unsigned   starve_m;
  logic          exp_i_rv, exp_d_rv;
  logic [DW-1:0] exp_rdata;
  logic          rstn_v;

  // Requester intent
  logic          i_pend, d_pend, d_rw_v;
  logic [AW-1:0] i_a, d_a;
  logic [DW-1:0] d_wd;
  logic          i_wait, d_wait;
  logic [AW-1:0] i_held, d_held;

  // Observations from the most recent cycle
  logic          last_i_gnt, last_d_gnt, last_m_csn, last_m_wen;
  logic          last_i_rv, last_d_rv;
  logic [AW-1:0] last_m_a;
  logic [DW-1:0] last_i_rdata, last_d_rdata;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check 1ns later, advance the model.
  task automatic cycle();
    logic ip, dp, ei, ed;
    @(negedge clk);
    if (i_wait) assert (i_pend && i_a == i_held)
      else $error("protocol: I_REQ dropped or I_ADDR changed before grant");
    if (d_wait) assert (d_pend && d_a == d_held)
      else $error("protocol: D_REQ dropped or D_ADDR changed before grant");
    rstn    = rstn_v;
    i_req   = i_pend;
    i_addr  = i_a;
    d_req   = d_pend;
    d_rw    = d_rw_v;
    d_addr  = d_a;
    d_wdata = d_wd;
    if (!rstn_v) begin
      exp_i_rv = 1'b0;
      exp_d_rv = 1'b0;
      starve_m = 0;
    end
    #1;
    ip = i_pend;
    dp = d_pend;
    // D wins any contest unless I has already been refused STARVE_MAX times.
    ed = rstn_v && dp && !(ip && starve_m >= STARVE_MAX);
    ei = rstn_v && ip && !ed;

    chk("i_gnt",    64'(i_gnt),    64'(ei));
    chk("d_gnt",    64'(d_gnt),    64'(ed));
    chk("m_csn",    64'(m_csn),    64'(!(ei || ed)));
    chk("m_wen",    64'(m_wen),    64'(!(ed && d_rw_v)));
    if (ei || ed) chk("m_a", 64'(m_a), 64'(ed ? d_a : i_a));
    if (ed && d_rw_v) chk("m_di", 64'(m_di), 64'(d_wd));
    chk("i_rvalid", 64'(i_rvalid), 64'(exp_i_rv));
    chk("d_rvalid", 64'(d_rvalid), 64'(exp_d_rv));
    if (exp_i_rv) chk("i_rdata", 64'(i_rdata), 64'(exp_rdata));
    if (exp_d_rv) chk("d_rdata", 64'(d_rdata), 64'(exp_rdata));

    last_i_gnt   = i_gnt;    last_d_gnt   = d_gnt;
    last_m_csn   = m_csn;    last_m_wen   = m_wen;   last_m_a = m_a;
    last_i_rv    = i_rvalid; last_d_rv    = d_rvalid;
    last_i_rdata = i_rdata;  last_d_rdata = d_rdata;

    exp_i_rv = 1'b0;
    exp_d_rv = 1'b0;
    if (rstn_v) begin
      if (ed) begin
        if (d_rw_v) ref_mem[d_a[7:0]] = d_wd;
        else begin
          exp_d_rv  = 1'b1;
          exp_rdata = ref_mem[d_a[7:0]];
        end
        d_pend = 1'b0;
      end
      if (ei) begin
        exp_i_rv  = 1'b1;
        exp_rdata = ref_mem[i_a[7:0]];
        i_pend    = 1'b0;
      end
      if (!ip || ei) starve_m = 0;
      else if (starve_m < 15) starve_m++;
      i_wait = ip && !ei;
      d_wait = dp && !ed;
      i_held = i_a;
      d_held = d_a;
    end
  endtask

  task automatic apply_reset();
    rstn_v = 1'b0;
    i_pend = 1'b0;
    d_pend = 1'b0;
    i_wait = 1'b0;
    d_wait = 1'b0;
    cycle();
    cycle();
    rstn_v = 1'b1;
  endtask

  task automatic req_i(input logic [AW-1:0] a);
    i_pend = 1'b1; i_a = a;
  endtask

  task automatic req_d(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_pend = 1'b1; d_rw_v = rw; d_a = a; d_wd = wd;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      sram[k]    = '0;
      ref_mem[k] = '0;
    end
    sram[8'h10] = 32'hDEADBEEF;  ref_mem[8'h10] = 32'hDEADBEEF;
    for (int k = 1; k <= 3; k++) begin
      sram[k]    = DW'(k);
      ref_mem[k] = DW'(k);
    end
    rstn = 1'b0; rstn_v = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_rw = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    i_a = '0; d_a = '0; d_wd = '0; d_rw_v = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; i_wait = 1'b0; d_wait = 1'b0;
    i_held = '0; d_held = '0;
    starve_m = 0; exp_i_rv = 1'b0; exp_d_rv = 1'b0; exp_rdata = '0;

    // Reset state
    apply_reset();
    chk("rst_csn", 64'(last_m_csn), 64'd1);
    chk("rst_wen", 64'(last_m_wen), 64'd1);

    // Fetch of 0x10 on an idle port
    req_i(30'h10);
    cycle();
    chk("t1_gnt", 64'(last_i_gnt), 64'd1);
    chk("t1_a",   64'(last_m_a),   64'h10);
    chk("t1_wen", 64'(last_m_wen), 64'd1);
    cycle();
    chk("t1_rv",   64'(last_i_rv),    64'd1);
    chk("t1_data", 64'(last_i_rdata), 64'hDEADBEEF);
    chk("t1_drv",  64'(last_d_rv),    64'd0);

    // Store then load of 0x20
    req_d(1'b1, 30'h20, 32'h12345678);
    cycle();
    chk("t2_wen0", 64'(last_m_wen), 64'd0);
    req_d(1'b0, 30'h20, 32'h0);
    cycle();
    chk("t2_wen1", 64'(last_m_wen), 64'd1);
    chk("t2_norv", 64'(last_d_rv),  64'd0);
    cycle();
    chk("t2_rv",   64'(last_d_rv),    64'd1);
    chk("t2_data", 64'(last_d_rdata), 64'h12345678);

    // Interleaved reads I 1, D 2, I 3
    req_i(30'h1); cycle();
    req_d(1'b0, 30'h2, 32'h0); cycle();
    chk("t4_i1", 64'(last_i_rdata), 64'h1);
    req_i(30'h3); cycle();
    chk("t4_d2", 64'(last_d_rdata), 64'h2);
    chk("t4_d2v", 64'(last_d_rv), 64'd1);
    cycle();
    chk("t4_i3", 64'(last_i_rdata), 64'h3);
    chk("t4_i3v", 64'(last_i_rv), 64'd1);

    // Reset right after a D read grant drops its response
    req_d(1'b0, 30'h2, 32'h0);
    cycle();
    chk("t5_gnt", 64'(last_d_gnt), 64'd1);
    rstn = 1'b0;  // before the rising edge that would capture the read
    rstn_v = 1'b0; exp_i_rv = 1'b0; exp_d_rv = 1'b0; starve_m = 0;
    req_i(30'h3);
    req_d(1'b0, 30'h1, 32'h0);
    cycle();
    chk("t5_drv",  64'(last_d_rv),  64'd0);
    chk("t5_igsn", 64'(last_i_gnt), 64'd0);
    cycle();
    rstn_v = 1'b1;
    cycle();
    chk("t5_first", 64'(last_d_gnt), 64'd1);
    cycle();
    chk("t5_ignt", 64'(last_i_gnt), 64'd1);
    cycle();

    // Continuous contention: D,D,D,D,I repeating
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      if (!i_pend) req_i(30'(k));
      if (!d_pend) req_d(1'b0, 30'(k), 32'h0);
      cycle();
      chk("t3_d", 64'(last_d_gnt), 64'((k % 5) != 4));
      chk("t3_i", 64'(last_i_gnt), 64'((k % 5) == 4));
    end
    cycle();
`ifdef ARB_STATS_EN
    chk("t6_d_cnt",  64'(d_gnt_cnt),  64'd16);
    chk("t6_i_cnt",  64'(i_gnt_cnt),  64'd4);
    chk("t6_starve", 64'(starve_hit), 64'd4);
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      if (!i_pend && $urandom_range(0, 3) != 0) req_i(30'($urandom_range(0, 15)));
      if (!d_pend && $urandom_range(0, 2) != 0)
        req_d(1'($urandom_range(0, 1)), 30'($urandom_range(0, 15)), $urandom);
      cycle();
    end
    i_pend = 1'b0;
    d_pend = 1'b0;
    i_wait = 1'b0;
    d_wait = 1'b0;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/toy_mem_arbiter.md
Name: toy_mem_arbiter

Overview:
Shares one single-port synchronous SRAM between the RISC_TOY instruction-fetch requester (I side) and the load/store requester (D side).
- Grants at most one access per cycle.
- Steers the address and write data onto the SRAM port.
- Returns read data to the owner one cycle later.
- Data side has priority; a starvation counter guarantees fetch progress.
- Sits between the core's IREQ/IADDR and DREQ/DRW/DADDR/DWDATA interfaces and a shared SRAM instance (CSN/WEN active low).

Parameters:
AW, 30, word-address width of both requesters and M_A
DW, 32, data width
STARVE_MAX, 4, consecutive cycles I_REQ may be denied before I wins (legal range 1..15)

Ports:
CLK  input  1  clock, rising edge
RSTN  input  1  asynchronous active-low reset
I_REQ  input  1  fetch request; held with I_ADDR stable until I_GNT
I_ADDR  input  AW  fetch word address
I_GNT  output  1  fetch accepted this cycle (combinational)
I_RVALID  output  1  I_RDATA valid (registered, one cycle after I_GNT)
I_RDATA  output  DW  fetch data
D_REQ  input  1  data request; held with D_RW, D_ADDR and D_WDATA stable until D_GNT
D_RW  input  1  1 = write, 0 = read
D_ADDR  input  AW  data word address
D_WDATA  input  DW  store data
D_GNT  output  1  data access accepted this cycle (combinational)
D_RVALID  output  1  D_RDATA valid (registered, one cycle after a read D_GNT)
D_RDATA  output  DW  load data
M_CSN  output  1  SRAM chip select, active low
M_WEN  output  1  SRAM write enable, active low
M_A  output  AW  SRAM address
M_DI  output  DW  SRAM write data
M_DOUT  input  DW  SRAM read data, valid the cycle after the access

Behaviour:
- Reset values while RSTN is low: I_GNT=0, D_GNT=0, I_RVALID=0, D_RVALID=0, M_CSN=1, M_WEN=1, starve_cnt=0. Grants are forced low during reset.
- Arbitration, evaluated each cycle:
  - I_REQ only: grant I.
  - D_REQ only: grant D.
  - Both requesting: grant D, unless starve_cnt >= STARVE_MAX, in which case grant I.
- At most one of I_GNT and D_GNT is high in any cycle.
- starve_cnt (4 bits):
  - Cleared to 0 on I_GNT, or in any cycle with I_REQ low.
  - Incremented when I_REQ=1 and I_GNT=0.
  - Saturates at 15.
- Port drive on a grant: M_CSN=0, M_A = the granted address.
  - I grant: M_WEN=1.
  - D grant: M_WEN = ~D_RW, M_DI = D_WDATA.
- With no grant: M_CSN=1, M_WEN=1. M_A and M_DI are don't-care but are held at the last driven value to limit toggling.
- Read return:
  - A 1-bit owner register plus a valid flag capture any granted read.
  - The next cycle, exactly one of I_RVALID or D_RVALID pulses for one cycle.
  - I_RDATA = D_RDATA = M_DOUT (combinational pass-through); each is qualified only by its own RVALID.
- Writes produce no RVALID. A write grant followed by a read grant on the next cycle is legal (fully pipelined, one access per cycle).
- Back-to-back reads by the same or different owners: one access per cycle; each response arrives in order, one cycle after its grant.
- Requesters must not drop REQ before GNT. Dropping REQ early is a protocol violation and is flagged by the bench assertion.
- Asynchronous reset mid-access: the pending response is discarded (no RVALID after release). The first grant is possible in the first clock after RSTN rises.
- Latency: grant is zero-wait on an idle port; read data arrives one cycle after grant.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds outputs I_GNT_CNT[15:0], D_GNT_CNT[15:0] and STARVE_HIT[15:0].
  - I_GNT_CNT and D_GNT_CNT count grants per side.
  - STARVE_HIT counts the cycles in which I won only through the starvation override.
  - All three are saturating, reset to 0, and registered.
- Not defined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
1. Reset, then I_REQ=1 with I_ADDR=0x10 held, SRAM word 0x10 = 0xDEADBEEF -> I_GNT=1 in the same cycle, M_CSN=0, M_A=0x10, M_WEN=1; next cycle I_RVALID=1 and I_RDATA=0xDEADBEEF; D_RVALID stays 0.
2. D write: D_REQ=1, D_RW=1, D_ADDR=0x20, D_WDATA=0x12345678, then a D read of 0x20 on the next cycle -> M_WEN=0 then 1; D_RVALID one cycle after the read grant, with D_RDATA=0x12345678.
3. Contention: I_REQ and D_REQ both held high continuously with STARVE_MAX=4 -> D granted 4 consecutive cycles, I granted in the 5th, starve_cnt back to 0, then D again; pattern repeats and grants are never simultaneous.
4. Interleaved reads: I read 0x1, D read 0x2, I read 0x3 on consecutive cycles (SRAM word n = n) -> RVALID pulses on I, D, I in order, with data 0x1, 0x2, 0x3.
5. Assert RSTN low in the cycle after a D read grant -> D_RVALID never pulses, all outputs return to reset values, and the first grant occurs in the first cycle after release.
6. ARB_STATS_EN build, run scenario 3 for 20 cycles -> D_GNT_CNT=16, I_GNT_CNT=4, STARVE_HIT=4.
